// File: rtl/mole_round_ctrl_pkg.sv
// Shared definitions for the whack-a-mole round sequencer: state encodings,
// datapath widths and the level-to-window mapping used at each mole launch.
package mole_round_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GAP  = 2'd1;
    localparam logic [1:0] ST_SHOW = 2'd2;
    localparam logic [1:0] ST_OVER = 2'd3;

    localparam int SCORE_W = 8;
    localparam int MISS_W  = 4;
    localparam int TIMER_W = 16;

    // Level 0 plays like level 1; the result never drops below min_w, even
    // when the level step would carry the window past zero.
    function automatic logic [TIMER_W-1:0] calc_window(
        input logic [3:0]         level,
        input logic [TIMER_W-1:0] base,
        input logic [TIMER_W-1:0] step,
        input logic [TIMER_W-1:0] min_w
    );
        logic [TIMER_W-1:0] lvl;
        logic [TIMER_W-1:0] dec;
        lvl = (level == 4'd0) ? TIMER_W'(1) : TIMER_W'(level);
        dec = (lvl - TIMER_W'(1)) * step;
        if ((dec >= base) || ((base - dec) < min_w)) begin
            return min_w;
        end
        return base - dec;
    endfunction

endpackage

// File: rtl/mole_round_ctrl_tick_prescaler.sv
// Free-running game tick generator: one-cycle tick every TICK_DIV enabled clocks.
// Holding enable low freezes the count so the tick phase survives a pause.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic clk,
    input  logic restart_n,
    input  logic enable,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge restart_n) begin
        if (!restart_n) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round sequencer: places each mole, times its window and the
// gap after it, judges button hits, and tracks score and misses to game end.
//
// state | meaning
// IDLE  | after reset, waiting for start
// GAP   | blank display, gap timer running toward next launch
// SHOW  | mole lit, window timer running, hits judged
// OVER  | miss limit reached, waiting for start
module mole_round_ctrl
    import mole_round_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 100000,
    parameter int unsigned BASE_WINDOW = 1000,
    parameter int unsigned STEP_WINDOW = 60,
    parameter int unsigned MIN_WINDOW  = 100,
    parameter int unsigned GAP_TICKS   = 300,
    parameter int unsigned MAX_MISSES  = 5
) (
    input  logic               clk,
    input  logic               restart_n,
    input  logic               start,
    input  logic               pause,
    input  logic [3:0]         level,
    input  logic [3:0]         hit,
    input  logic [7:0]         rand_val,
    output logic [3:0]         mole_onehot,
    output logic [SCORE_W-1:0] score,
    output logic [MISS_W-1:0]  misses,
    output logic               game_over,
    output logic               hit_ok,
    output logic               miss
);

    localparam logic [TIMER_W-1:0] GAP_LOAD  = TIMER_W'(GAP_TICKS);
    localparam logic [TIMER_W-1:0] BASE_LOAD = TIMER_W'(BASE_WINDOW);
    localparam logic [TIMER_W-1:0] STEP_LOAD = TIMER_W'(STEP_WINDOW);
    localparam logic [TIMER_W-1:0] MIN_LOAD  = TIMER_W'(MIN_WINDOW);
    localparam logic [MISS_W-1:0]  MISS_MAX  = MISS_W'(MAX_MISSES);

    logic [1:0]         state;
    logic [TIMER_W-1:0] timer;
    logic [1:0]         pos;
    logic [1:0]         last_pos;
    logic               tick;

    logic [1:0]         launch_pos;
    logic [3:0]         mole_mask;
    logic               timer_done;
    logic [MISS_W-1:0]  misses_inc;
    logic               last_miss;
    logic               unused_rand;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk       (clk),
        .restart_n (restart_n),
        .enable    (!pause),
        .tick      (tick)
    );

    // Never relaunch on the digit that just went dark.
    assign launch_pos  = (rand_val[1:0] == last_pos) ? rand_val[1:0] + 2'd1 : rand_val[1:0];
    assign unused_rand = ^rand_val[7:2];

    assign mole_mask   = 4'b0001 << pos;
    assign timer_done  = (timer <= TIMER_W'(1));
    assign misses_inc  = misses + 1'b1;
    assign last_miss   = (misses_inc >= MISS_MAX);

    assign mole_onehot = ((state == ST_SHOW) && !pause) ? mole_mask : 4'b0000;
    assign game_over   = (state == ST_OVER);

    always_ff @(posedge clk or negedge restart_n) begin
        if (!restart_n) begin
            state    <= ST_IDLE;
            timer    <= '0;
            pos      <= 2'd0;
            last_pos <= 2'd0;
            score    <= '0;
            misses   <= '0;
            hit_ok   <= 1'b0;
            miss     <= 1'b0;
        end else begin
            hit_ok <= 1'b0;
            miss   <= 1'b0;
            case (state)
                ST_IDLE, ST_OVER: begin
                    if (start) begin
                        state  <= ST_GAP;
                        timer  <= GAP_LOAD;
                        score  <= '0;
                        misses <= '0;
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        if (timer_done) begin
                            state    <= ST_SHOW;
                            pos      <= launch_pos;
                            last_pos <= launch_pos;
                            timer    <= calc_window(level, BASE_LOAD, STEP_LOAD, MIN_LOAD);
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                end
                ST_SHOW: begin
                    // A hit landing on the timeout tick wins over the timeout.
                    if (!pause) begin
                        if (hit == mole_mask) begin
                            score  <= (score == '1) ? score : score + 1'b1;
                            hit_ok <= 1'b1;
                            state  <= ST_GAP;
                            timer  <= GAP_LOAD;
                        end else if ((hit != 4'b0000) || (tick && timer_done)) begin
                            miss <= 1'b1;
                            if (last_miss) begin
                                misses <= MISS_MAX;
                                state  <= ST_OVER;
                            end else begin
                                misses <= misses_inc;
                                state  <= ST_GAP;
                                timer  <= GAP_LOAD;
                            end
                        end else if (tick) begin
                            timer <= timer - 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
